// File: rtl/softmax_pkg_16.sv
// Shared definitions for the 16-bit softmax output packer.
package softmax_pkg_16;

  localparam int unsigned DATA_SIZE = 16;
  localparam int unsigned KEEP_W    = 2 * DATA_SIZE / 8;
  localparam int unsigned ENTRY_W   = 2 * DATA_SIZE + KEEP_W + 1;

  // Packed-word FIFO entry; top of the entry is last, bottom is data.
  typedef struct packed {
    logic                     last;
    logic [KEEP_W-1:0]        keep;
    logic [2*DATA_SIZE-1:0]   data;
  } fifo_entry_t;

  // Pack FSM: StHalf means the low lane register holds a pending result.
  typedef enum logic [0:0] {
    StEmpty,
    StHalf
  } pack_state_e;

endpackage

// File: rtl/sync_fifo_16.sv
// Show-ahead synchronous FIFO: head entry is visible on rdata without a pop.
module sync_fifo_16 #(
  parameter int unsigned width = 37,
  parameter int unsigned depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [width-1:0] mem_q [depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CntW'(depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/softmax_output_packer_16.sv
// Packs pairs of 16-bit softmax results into 32-bit words for the DMA write path.
module softmax_output_packer_16
  import softmax_pkg_16::*;
#(
  parameter int unsigned data_size  = DATA_SIZE,
  parameter int unsigned fifo_depth = 4
) (
  input  logic                       axi_clock_i,
  input  logic                       axi_reset_i,
  input  logic                       s_axis_valid_i,
  input  logic [data_size-1:0]       s_axis_data_i,
  input  logic                       s_axis_last_i,
  output logic                       s_axis_ready_o,
  input  logic                       m_axis_ready_i,
  output logic                       m_axis_valid_o,
  output logic [2*data_size-1:0]     m_axis_data_o,
  output logic [2*data_size/8-1:0]   m_axis_keep_o,
  output logic                       m_axis_last_o,
  output logic [7:0]                 pkt_count_o
);

  localparam int unsigned KeepW  = 2 * data_size / 8;
  localparam int unsigned EntryW = 2 * data_size + KeepW + 1;
  localparam logic [KeepW-1:0] KeepLow = {{(KeepW/2){1'b0}}, {(KeepW/2){1'b1}}};
  localparam logic [KeepW-1:0] KeepAll = {KeepW{1'b1}};

  pack_state_e           state_q, state_d;
  logic [data_size-1:0]  low_q, low_d;
  logic [7:0]            pkt_count_q;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [EntryW-1:0]     push_entry;
  logic [EntryW-1:0]     head_entry;

  assign s_axis_ready_o = !fifo_full;
  assign accept         = s_axis_valid_i && s_axis_ready_o;
  assign m_axis_valid_o = !fifo_empty;
  assign pop            = m_axis_valid_o && m_axis_ready_i;
  assign pkt_count_o    = pkt_count_q;

  // Head fields are masked to zero while the FIFO holds nothing.
  assign {m_axis_last_o, m_axis_keep_o, m_axis_data_o} = fifo_empty ? '0 : head_entry;

  // Pack FSM next state and FIFO push request; entry layout is {last, keep, data}.
  always_comb begin
    state_d    = state_q;
    low_d      = low_q;
    push       = 1'b0;
    push_entry = '0;
    if (accept) begin
      unique case (state_q)
        StEmpty: begin
          if (s_axis_last_i) begin
            push       = 1'b1;
            push_entry = {1'b1, KeepLow, {data_size{1'b0}}, s_axis_data_i};
          end else begin
            low_d   = s_axis_data_i;
            state_d = StHalf;
          end
        end
        StHalf: begin
          push       = 1'b1;
          push_entry = {s_axis_last_i, KeepAll, s_axis_data_i, low_q};
          state_d    = StEmpty;
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Pack state, pending low lane and completed-packet counter.
  always_ff @(posedge axi_clock_i or posedge axi_reset_i) begin
    if (axi_reset_i) begin
      state_q     <= StEmpty;
      low_q       <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      if (pop && m_axis_last_o) begin
        pkt_count_q <= pkt_count_q + 8'd1;
      end
    end
  end

  sync_fifo_16 #(
    .width (EntryW),
    .depth (fifo_depth)
  ) u_fifo (
    .clk_i   (axi_clock_i),
    .rst_i   (axi_reset_i),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_softmax_output_packer_16.sv
// Directed bench for softmax_output_packer_16: vector table plus corner-case sequences.
module tb_softmax_output_packer_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic        m_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic [7:0]  pkt_count;

  always #5 clk = ~clk;

  softmax_output_packer_16 dut (
    .axi_clock_i    (clk),
    .axi_reset_i    (rst),
    .s_axis_valid_i (s_valid),
    .s_axis_data_i  (s_data),
    .s_axis_last_i  (s_last),
    .s_axis_ready_o (s_ready),
    .m_axis_ready_i (m_ready),
    .m_axis_valid_o (m_valid),
    .m_axis_data_o  (m_data),
    .m_axis_keep_o  (m_keep),
    .m_axis_last_o  (m_last),
    .pkt_count_o    (pkt_count)
  );

  typedef struct {
    string            name;
    int               n_lanes;
    logic [3:0][15:0] lane;
    int               n_words;
    logic [1:0][31:0] wdata;
    logic [1:0][3:0]  wkeep;
    logic [1:0]       wlast;
  } vec_t;

  vec_t        vecs [4];
  int          checks = 0;
  int          errors = 0;
  int          exp_pkt;
  logic        acc;
  logic [31:0] got_data [$];
  logic [3:0]  got_keep [$];
  logic        got_last [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, return just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    acc = s_valid && s_ready;
    if (m_valid && m_ready) begin
      got_data.push_back(m_data);
      got_keep.push_back(m_keep);
      got_last.push_back(m_last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_data.delete();
    got_keep.delete();
    got_last.delete();
  endtask

  task automatic send_lane(input logic [15:0] d, input logic l, input bit rnd);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int t = 0; t < 200 && !done; t++) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      cycle();
      if (acc) done = 1'b1;
    end
    s_valid = 1'b0;
    if (!done) chk($sformatf("send_timeout_%0h", d), 32'(done), 32'd1);
  endtask

  task automatic drain();
    m_ready = 1'b1;
    s_valid = 1'b0;
    for (int t = 0; t < 100 && m_valid; t++) cycle();
    if (m_valid) chk("drain_timeout", 32'(m_valid), 32'd0);
  endtask

  task automatic check_word(input string name, input int idx, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
    if (idx >= got_data.size()) begin
      checks++;
      errors++;
      $display("FAIL %s[%0d]: missing word, expected data 0x%08h", name, idx, d);
    end else begin
      chk($sformatf("%s[%0d].data", name, idx), got_data[idx], d);
      chk($sformatf("%s[%0d].keep", name, idx), 32'(got_keep[idx]), 32'(k));
      chk($sformatf("%s[%0d].last", name, idx), 32'(got_last[idx]), 32'(l));
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"even", 4, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 2,
                {32'h0004_0003, 32'h0002_0001}, {4'hF, 4'hF}, 2'b10};
    vecs[1] = '{"odd", 3, {16'h0000, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 2,
                {32'h0000_CCCC, 32'hBBBB_AAAA}, {4'h3, 4'hF}, 2'b10};
    vecs[2] = '{"single", 1, {16'h0, 16'h0, 16'h0, 16'h1234}, 1,
                {32'h0, 32'h0000_1234}, {4'h0, 4'h3}, 2'b01};
    vecs[3] = '{"pair", 2, {16'h0, 16'h0, 16'hBEEF, 16'hDEAD}, 1,
                {32'h0, 32'hBEEF_DEAD}, {4'h0, 4'hF}, 2'b01};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_keep", 32'(m_keep), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    exp_pkt = 0;

    // Table-driven packets with the DMA always ready.
    for (int v = 0; v < 4; v++) begin
      clear_got();
      m_ready = 1'b1;
      for (int k = 0; k < vecs[v].n_lanes; k++) begin
        send_lane(vecs[v].lane[k], (k == vecs[v].n_lanes - 1), 1'b0);
      end
      drain();
      chk({vecs[v].name, "_nwords"}, 32'(got_data.size()), 32'(vecs[v].n_words));
      for (int w = 0; w < vecs[v].n_words; w++) begin
        check_word(vecs[v].name, w, vecs[v].wdata[w], vecs[v].wkeep[w], vecs[v].wlast[w]);
      end
      exp_pkt++;
      chk({vecs[v].name, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkt));
    end

    // Single-lane latency: word visible right after the accepting edge.
    clear_got();
    m_ready = 1'b1;
    chk("lat_pre_valid", 32'(m_valid), 32'd0);
    s_valid = 1'b1; s_data = 16'h1234; s_last = 1'b1;
    cycle();
    s_valid = 1'b0;
    chk("lat_accept", 32'(acc), 32'd1);
    chk("lat_valid", 32'(m_valid), 32'd1);
    chk("lat_data", m_data, 32'h0000_1234);
    chk("lat_keep", 32'(m_keep), 32'h3);
    chk("lat_last", 32'(m_last), 32'd1);
    drain();
    chk("lat_nwords", 32'(got_data.size()), 32'd1);
    exp_pkt++;
    chk("lat_pkt_count", 32'(pkt_count), 32'(exp_pkt));

    // Backpressure: ten lanes offered continuously while the DMA stalls.
    begin
      int idx = 1;
      clear_got();
      m_ready = 1'b0;
      for (int t = 0; t < 12; t++) begin
        s_valid = 1'b1; s_data = 16'(idx); s_last = (idx == 10);
        cycle();
        if (acc) idx++;
        if (t >= 9) chk($sformatf("bp_hold_%0d", t), m_data, 32'h0002_0001);
      end
      chk("bp_accepted", 32'(idx - 1), 32'd8);
      chk("bp_s_ready", 32'(s_ready), 32'd0);
      chk("bp_m_valid", 32'(m_valid), 32'd1);
      m_ready = 1'b1;
      for (int t = 0; t < 50 && idx <= 10; t++) begin
        s_valid = 1'b1; s_data = 16'(idx); s_last = (idx == 10);
        cycle();
        if (acc) idx++;
      end
      s_valid = 1'b0;
      chk("bp_all_accepted", 32'(idx), 32'd11);
      drain();
      chk("bp_nwords", 32'(got_data.size()), 32'd5);
      for (int w = 0; w < 5; w++) begin
        check_word("bp", w, {16'(2 * w + 2), 16'(2 * w + 1)}, 4'hF, (w == 4));
      end
      exp_pkt++;
      chk("bp_pkt_count", 32'(pkt_count), 32'(exp_pkt));
    end

    // Reset mid-packet with a word queued and a half-packed lane pending.
    clear_got();
    m_ready = 1'b0;
    send_lane(16'h1111, 1'b1, 1'b0);
    send_lane(16'h5555, 1'b0, 1'b0);
    chk("mid_pre_valid", 32'(m_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_data", m_data, 32'd0);
    chk("mid_rst_keep", 32'(m_keep), 32'd0);
    chk("mid_rst_last", 32'(m_last), 32'd0);
    chk("mid_rst_pkt", 32'(pkt_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready = 1'b1;
    send_lane(16'h0007, 1'b0, 1'b0);
    send_lane(16'h0008, 1'b1, 1'b0);
    drain();
    chk("mid_nwords", 32'(got_data.size()), 32'd1);
    check_word("mid", 0, 32'h0008_0007, 4'hF, 1'b1);
    chk("mid_pkt_count", 32'(pkt_count), 32'd1);

    // 256 single-lane packets with random DMA stalls: counter wraps to zero.
    pulse_reset();
    clear_got();
    chk("wrap_start_pkt", 32'(pkt_count), 32'd0);
    for (int i = 0; i < 256; i++) send_lane(16'(i), 1'b1, 1'b1);
    drain();
    chk("wrap_nwords", 32'(got_data.size()), 32'd256);
    for (int i = 0; i < 256; i++) check_word("wrap", i, {16'h0, 16'(i)}, 4'h3, 1'b1);
    chk("wrap_pkt_count", 32'(pkt_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
